kogge_stone_adder_pipe: RTL and testbench

Parametrised, pipelined Kogge-Stone adder/subtractor, the generalised successor to the team's fixed 8-bit prefix adder. It takes WIDTH-bit operands through a valid/ready handshake and computes one prefix level per pipeline stage. Results come out with carry-out, signed-overflow and zero flags. It sits in the datapath wherever a wide add/sub has to close timing at full clock rate, for example in accumulators and address generators.

---
 rtl/kogge_stone_adder_pipe_pkg.sv | 46 ++++
 rtl/kogge_stone_adder_pipe_cell.sv | 24 ++
 rtl/kogge_stone_adder_pipe.sv | 131 +++++++++++++
 tb/tb_kogge_stone_adder_pipe.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kogge_stone_adder_pipe_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder: width math, legality
// check and the bit layout of the record carried from stage to stage.
package ks_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic bit width_ok(input int width);
    return (width >= 8) && (width <= 64) && ((width & (width - 1)) == 0);
  endfunction

  // Stage record, LSB first: G[w], A[w], P[w], c0, sign(a), sign(b').
  function automatic int rec_width(input int width);
    return 3 * width + 3;
  endfunction

  function automatic int rec_a_lsb(input int width);
    return width;
  endfunction

  function automatic int rec_p_lsb(input int width);
    return 2 * width;
  endfunction

  function automatic int rec_c0_bit(input int width);
    return 3 * width;
  endfunction

  function automatic int rec_sa_bit(input int width);
    return 3 * width + 1;
  endfunction

  function automatic int rec_sb_bit(input int width);
    return 3 * width + 2;
  endfunction

endpackage

// File: rtl/kogge_stone_adder_pipe_cell.sv
// One prefix-tree node. Grey nodes already span down to the carry-in, so
// only their generate is meaningful; black nodes also produce alive.
module ks_prefix_cell #(
  parameter bit GREY = 1'b0
) (
  input  logic g_hi,
  input  logic a_hi,
  input  logic g_lo,
  input  logic a_lo,
  output logic g_out,
  output logic a_out
);

  assign g_out = g_hi | (a_hi & g_lo);

  if (GREY) begin : g_grey
    logic unused_a_lo;
    assign a_out       = 1'b0;
    assign unused_a_lo = a_lo;
  end else begin : g_black
    assign a_out = a_hi & a_lo;
  end

endmodule

// File: rtl/kogge_stone_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor: preprocess, one prefix level per
// stage, then a registered sum stage, all under a single global enable.
module kogge_stone_adder_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int L   = clog2(WIDTH);
  localparam int RW  = rec_width(WIDTH);
  localparam int AO  = rec_a_lsb(WIDTH);
  localparam int PO  = rec_p_lsb(WIDTH);
  localparam int CO  = rec_c0_bit(WIDTH);
  localparam int SAO = rec_sa_bit(WIDTH);
  localparam int SBO = rec_sb_bit(WIDTH);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("kogge_stone_adder_pipe: WIDTH must be a power of two in 8..64");
  end

  logic          en;
  logic [RW-1:0] rec_d [0:L];
  logic [RW-1:0] rec_q [0:L];
  logic [L:0]    vld_d;
  logic [L:0]    vld_q;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic [WIDTH-1:0] b_x, g_raw, g_pre, a_pre, p_pre;
  logic             c0;

  assign b_x   = in_b ^ {WIDTH{in_sub}};
  assign c0    = in_sub | in_cin;
  assign g_raw = in_a & b_x;
  assign a_pre = in_a | b_x;
  assign p_pre = in_a ^ b_x;
  // Carry-in is absorbed into bit 0 so the L-level tree reaches every bit.
  assign g_pre = {g_raw[WIDTH-1:1], g_raw[0] | (a_pre[0] & c0)};
  assign rec_d[0] = {b_x[WIDTH-1], in_a[WIDTH-1], c0, p_pre, a_pre, g_pre};

  assign vld_d = {vld_q[L-1:0], in_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int s = 0; s <= L; s++) begin
        rec_q[s] <= rec_d[s];
      end
    end
  end

  for (genvar k = 1; k <= L; k++) begin : g_level
    localparam int D = 1 << (k - 1);
    logic [WIDTH-1:0] g_p, a_p, g_n, a_n;

    assign g_p = rec_q[k-1][0 +: WIDTH];
    assign a_p = rec_q[k-1][AO +: WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i < D) begin : g_pass
        assign g_n[i] = g_p[i];
        assign a_n[i] = a_p[i];
      end else begin : g_node
        ks_prefix_cell #(
          .GREY (i < 2 * D)
        ) u_cell (
          .g_hi  (g_p[i]),
          .a_hi  (a_p[i]),
          .g_lo  (g_p[i-D]),
          .a_lo  (a_p[i-D]),
          .g_out (g_n[i]),
          .a_out (a_n[i])
        );
      end
    end

    assign rec_d[k] = {rec_q[k-1][RW-1:PO], a_n, g_n};
  end

  logic [WIDTH-1:0] g_f, p_f, sum_d;
  logic             c0_f, sa_f, sb_f;
  logic             unused_alive;

  assign g_f          = rec_q[L][0 +: WIDTH];
  assign p_f          = rec_q[L][PO +: WIDTH];
  assign c0_f         = rec_q[L][CO];
  assign sa_f         = rec_q[L][SAO];
  assign sb_f         = rec_q[L][SBO];
  assign unused_alive = ^rec_q[L][AO +: WIDTH];
  assign sum_d        = p_f ^ {g_f[WIDTH-2:0], c0_f};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (en) begin
      out_valid <= vld_q[L];
      out_sum   <= sum_d;
      out_cout  <= g_f[WIDTH-1];
      out_ovf   <= (sa_f == sb_f) && (sum_d[WIDTH-1] != sa_f);
      out_zero  <= ~|sum_d;
    end
  end

endmodule

// File: tb/tb_kogge_stone_adder_pipe.sv
// Directed bench for the pipelined Kogge-Stone adder at widths 8, 16, 32, 64.
// Index 0..3 selects the 8/16/32/64-bit instance.
module tb_kogge_stone_adder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_a, in_b;
  logic        in_cin, in_sub;
  logic [3:0]  iv, ordy;
  wire  [3:0]  ir, ov, co, of, zr;
  wire  [7:0]  s8;
  wire  [15:0] s16;
  wire  [31:0] s32;
  wire  [63:0] s64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  kogge_stone_adder_pipe #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(s8),
    .out_cout(co[0]), .out_ovf(of[0]), .out_zero(zr[0]));

  kogge_stone_adder_pipe #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(s16),
    .out_cout(co[1]), .out_ovf(of[1]), .out_zero(zr[1]));

  kogge_stone_adder_pipe #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(s32),
    .out_cout(co[2]), .out_ovf(of[2]), .out_zero(zr[2]));

  kogge_stone_adder_pipe #(.WIDTH(64)) u_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_sum(s64),
    .out_cout(co[3]), .out_ovf(of[3]), .out_zero(zr[3]));

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic get_out(input int sel, output logic v, output logic [63:0] s,
                         output logic c, output logic o, output logic z);
    v = ov[sel];
    c = co[sel];
    o = of[sel];
    z = zr[sel];
    case (sel)
      0:       s = {56'b0, s8};
      1:       s = {48'b0, s16};
      2:       s = {32'b0, s32};
      default: s = s64;
    endcase
  endtask

  // One isolated beat; latency counts clock edges from the accepting edge.
  task automatic applyStimulus(input int sel, input string tag,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic cin, input logic sub,
                               input logic [63:0] es, input logic ec,
                               input logic eo, input logic ez);
    logic        v, c, o, z, found;
    logic [63:0] s;
    int          lat;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    iv[sel] = 1'b1;
    @(posedge clk); #1;
    iv[sel] = 1'b0;
    lat = 1;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      get_out(sel, v, s, c, o, z);
      if (v) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    checkOutput({tag, ".seen"}, found, 1'b1);
    if (found) begin
      checkOutput({tag, ".sum"}, s, es);
      checkOutput({tag, ".cout"}, c, ec);
      checkOutput({tag, ".ovf"}, o, eo);
      checkOutput({tag, ".zero"}, z, ez);
      checkOutput({tag, ".latency"}, lat, sel + 5);
    end
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] sum;
    logic        cout, ovf, zero;
  } vec32_t;

  vec32_t st [8] = '{
    '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1},
    '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0},
    '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1},
    '{32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0},
    '{32'h00000010, 32'h00000001, 1'b0, 1'b1, 32'h0000000F, 1'b1, 1'b0, 1'b0},
    '{32'h00000000, 32'h00000001, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0},
    '{32'hDEADBEEF, 32'h00000001, 1'b1, 1'b0, 32'hDEADBEF1, 1'b0, 1'b0, 1'b0},
    '{32'h55555555, 32'hAAAAAAAA, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}
  };

  logic [7:0] exp_bp [10] = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45,
                              8'h56, 8'h67, 8'h78, 8'h89, 8'h9A};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        v, c, o, z;
    logic [63:0] s;
    int          oidx, in_idx, out_idx, ghosts;

    rst_n = 1'b0;
    iv = 4'h0; ordy = 4'hF;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int sel = 0; sel < 4; sel++) begin
      get_out(sel, v, s, c, o, z);
      checkOutput($sformatf("reset[%0d].out_valid", sel), v, 1'b0);
      checkOutput($sformatf("reset[%0d].out_sum", sel), s, 64'h0);
      checkOutput($sformatf("reset[%0d].flags", sel), {c, o, z}, 3'b000);
      checkOutput($sformatf("reset[%0d].in_ready", sel), ir[sel], 1'b1);
    end

    applyStimulus(0, "w8.ff_plus_1",  64'hFF, 64'h01, 1'b0, 1'b0, 64'h00, 1'b1, 1'b0, 1'b1);
    applyStimulus(0, "w8.7f_plus_1",  64'h7F, 64'h01, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, "w8.5_minus_7",  64'h05, 64'h07, 1'b0, 1'b1, 64'hFE, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, "w8.80_minus_1", 64'h80, 64'h01, 1'b0, 1'b1, 64'h7F, 1'b1, 1'b1, 1'b0);
    applyStimulus(0, "w8.sub_cin_ign", 64'h05, 64'h07, 1'b1, 1'b1, 64'hFE, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, "w8.add_cin",    64'h10, 64'h20, 1'b1, 1'b0, 64'h31, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, "w8.40_minus_40", 64'h40, 64'h40, 1'b0, 1'b1, 64'h00, 1'b1, 1'b0, 1'b1);

    applyStimulus(1, "w16.ones_plus_1", 64'hFFFF, 64'h0001, 1'b0, 1'b0, 64'h0000, 1'b1, 1'b0, 1'b1);
    applyStimulus(1, "w16.alt",         64'hAAAA, 64'h5555, 1'b0, 1'b0, 64'hFFFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, "w16.alt_cin",     64'hAAAA, 64'h5555, 1'b1, 1'b0, 64'h0000, 1'b1, 1'b0, 1'b1);
    applyStimulus(1, "w16.min_minus_1", 64'h8000, 64'h0001, 1'b0, 1'b1, 64'h7FFF, 1'b1, 1'b1, 1'b0);

    applyStimulus(3, "w64.ones_plus_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                  64'h0, 1'b1, 1'b0, 1'b1);
    applyStimulus(3, "w64.alt_cin", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0,
                  64'h0, 1'b1, 1'b0, 1'b1);
    applyStimulus(3, "w64.max_plus_1", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                  64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(3, "w64.0_minus_1", 64'h0, 64'h1, 1'b0, 1'b1,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream: results must appear on consecutive cycles from cycle 7.
    oidx = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 8) begin
        in_a = {32'b0, st[cyc].a}; in_b = {32'b0, st[cyc].b};
        in_cin = st[cyc].cin; in_sub = st[cyc].sub;
        iv[2] = 1'b1;
      end else begin
        iv[2] = 1'b0;
      end
      @(negedge clk);
      if (cyc < 8) checkOutput("stream.in_ready", ir[2], 1'b1);
      get_out(2, v, s, c, o, z);
      if (v) begin
        if (oidx < 8) begin
          checkOutput($sformatf("stream[%0d].sum", oidx), s, {32'b0, st[oidx].sum});
          checkOutput($sformatf("stream[%0d].cout", oidx), c, st[oidx].cout);
          checkOutput($sformatf("stream[%0d].ovf", oidx), o, st[oidx].ovf);
          checkOutput($sformatf("stream[%0d].zero", oidx), z, st[oidx].zero);
          checkOutput($sformatf("stream[%0d].cycle", oidx), cyc, 7 + oidx);
        end else begin
          checkOutput("stream.extra_result", oidx, 7);
        end
        oidx++;
      end
    end
    checkOutput("stream.count", oidx, 8);

    // Random in_valid and 30% out_ready; the held value must always be the next expected one.
    in_idx = 0;
    out_idx = 0;
    for (int cyc = 0; cyc < 160; cyc++) begin
      @(posedge clk); #1;
      in_a = {56'b0, 8'(in_idx * 17)}; in_b = 64'h1; in_cin = 1'b0; in_sub = 1'b0;
      if (cyc < 130) begin
        iv[0]   = (in_idx < 10) && ($urandom_range(0, 1) == 1);
        ordy[0] = ($urandom_range(0, 9) < 3);
      end else begin
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
      end
      @(negedge clk);
      get_out(0, v, s, c, o, z);
      if (v) begin
        if (out_idx < 10) checkOutput($sformatf("bp[%0d].sum", out_idx), s, {56'b0, exp_bp[out_idx]});
        else              checkOutput("bp.duplicate", out_idx, 9);
        if (!ordy[0]) checkOutput("bp.in_ready_stall", ir[0], 1'b0);
        if (ordy[0]) out_idx++;
      end
      if (iv[0] && ir[0]) in_idx++;
    end
    checkOutput("bp.accepted", in_idx, 10);
    checkOutput("bp.delivered", out_idx, 10);
    ordy[0] = 1'b1;

    // Reset while the first of three beats is on the output.
    @(posedge clk); #1;
    in_a = 64'h01; in_b = 64'h02; in_cin = 1'b0; in_sub = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    in_a = 64'h10; in_b = 64'h20;
    @(posedge clk); #1;
    in_a = 64'h30; in_b = 64'h40;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    get_out(0, v, s, c, o, z);
    checkOutput("rst.pre_valid", v, 1'b1);
    checkOutput("rst.pre_sum", s, 64'h03);
    rst_n = 1'b0;
    #1;
    get_out(0, v, s, c, o, z);
    checkOutput("rst.out_valid_now", v, 1'b0);
    checkOutput("rst.out_sum_now", s, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ghosts = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (ov[0]) ghosts++;
    end
    checkOutput("rst.ghost_results", ghosts, 0);
    checkOutput("rst.in_ready", ir[0], 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
